// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-port RAM between
// two requesters; range-checks addresses and returns read data to the owner.
module ram_port_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_err,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_err,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              wr,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] datain,
  input  logic [DWIDTH-1:0] dataout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  // One extra bit so DEPTH == 2**AWIDTH still compares correctly.
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [2:0]      LAT_W   = 3'(RD_LAT);

  state_t            state, state_nx;
  logic              last_grant, last_grant_nx;
  logic              owner, owner_nx;
  logic              cmd_wr, cmd_wr_nx;
  logic              cmd_ok, cmd_ok_nx;
  logic [2:0]        cnt, cnt_nx;
  logic              m0_gnt_nx, m0_err_nx, m0_rvalid_nx;
  logic              m1_gnt_nx, m1_err_nx, m1_rvalid_nx;
  logic [DWIDTH-1:0] m0_rdata_nx, m1_rdata_nx;
  logic              wr_nx;
  logic [AWIDTH-1:0] addr_nx;
  logic [DWIDTH-1:0] datain_nx;

  // last_grant: 0 = m0 was served last, 1 = m1 was served last.
  logic              pick_m1;
  logic              sel_wr;
  logic              sel_ok;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;

  assign pick_m1   = m1_req && (!m0_req || !last_grant);
  assign sel_wr    = pick_m1 ? m1_wr    : m0_wr;
  assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  assign sel_ok    = {1'b0, sel_addr} < DEPTH_W;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx      = state;
    last_grant_nx = last_grant;
    owner_nx      = owner;
    cmd_wr_nx     = cmd_wr;
    cmd_ok_nx     = cmd_ok;
    cnt_nx        = cnt;
    m0_gnt_nx     = 1'b0;
    m0_err_nx     = 1'b0;
    m0_rvalid_nx  = 1'b0;
    m1_gnt_nx     = 1'b0;
    m1_err_nx     = 1'b0;
    m1_rvalid_nx  = 1'b0;
    m0_rdata_nx   = m0_rdata;
    m1_rdata_nx   = m1_rdata;
    wr_nx         = 1'b0;
    addr_nx       = addr;
    datain_nx     = datain;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nx      = ACCESS;
          owner_nx      = pick_m1;
          last_grant_nx = pick_m1;
          cmd_wr_nx     = sel_wr;
          cmd_ok_nx     = sel_ok;
          m0_gnt_nx     = !pick_m1;
          m1_gnt_nx     = pick_m1;
          m0_err_nx     = !pick_m1 && !sel_ok;
          m1_err_nx     = pick_m1 && !sel_ok;
          wr_nx         = sel_wr && sel_ok;
          addr_nx       = sel_ok ? sel_addr : '0;
          datain_nx     = sel_wr ? sel_wdata : '0;
        end
      end
      ACCESS: begin
        if (cmd_wr || !cmd_ok) begin
          state_nx = IDLE;
        end else begin
          state_nx = RDWAIT;
          cnt_nx   = LAT_W;
        end
      end
      RDWAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nx = IDLE;
          if (owner) begin
            m1_rvalid_nx = 1'b1;
            m1_rdata_nx  = dataout;
          end else begin
            m0_rvalid_nx = 1'b1;
            m0_rdata_nx  = dataout;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_ok     <= 1'b0;
      cnt        <= '0;
      m0_gnt     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_gnt     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rvalid  <= 1'b0;
      m1_rdata   <= '0;
      wr         <= 1'b0;
      addr       <= '0;
      datain     <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      owner      <= owner_nx;
      cmd_wr     <= cmd_wr_nx;
      cmd_ok     <= cmd_ok_nx;
      cnt        <= cnt_nx;
      m0_gnt     <= m0_gnt_nx;
      m0_err     <= m0_err_nx;
      m0_rvalid  <= m0_rvalid_nx;
      m0_rdata   <= m0_rdata_nx;
      m1_gnt     <= m1_gnt_nx;
      m1_err     <= m1_err_nx;
      m1_rvalid  <= m1_rvalid_nx;
      m1_rdata   <= m1_rdata_nx;
      wr         <= wr_nx;
      addr       <= addr_nx;
      datain     <= datain_nx;
    end
  end

endmodule
